// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and helpers for the iterative RV32M multiply/divide unit.
// Optional build macro: MULDIV_EARLY_OUT_EN (see muldiv_sequencer.sv).
package muldiv_sequencer_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] RES_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] RES_MIN_INT  = 32'h8000_0000;

  function automatic logic op_signed1(input logic [2:0] op);
    return op[2] ? ~op[0] : ((op == OP_MULH) || (op == OP_MULHSU));
  endfunction

  function automatic logic op_signed2(input logic [2:0] op);
    return op[2] ? ~op[0] : (op == OP_MULH);
  endfunction

  // Operations whose result is known without iterating.
  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    if (op[2]) return (b == '0) || (!op[0] && (a == RES_MIN_INT) && (b == RES_ALL_ONES));
    return (a == '0) || (b == '0);
  endfunction

  function automatic logic [31:0] special_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
    if (!op[2]) return '0;
    if (b == '0) return op[1] ? a : RES_ALL_ONES;
    return op[1] ? '0 : RES_MIN_INT;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_is_div,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  // Multiply: {hi,lo} with multiplier in lo; add to hi on lo[0], then shift right.
  assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
  // Divide: {rem,quot} shifted left; 33-bit partial remainder compared to divisor.
  assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, i_operand};
  assign w_ge     = ~w_diff[XLEN+1];

  always_comb begin
    o_qbit = 1'b0;
    o_acc  = {w_sum, i_acc[XLEN-1:1]};
    if (i_is_div) begin
      o_qbit = w_ge;
      o_acc  = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: IDLE -> CALC (32 steps) -> FIX -> DONE.
// Build macro MULDIV_EARLY_OUT_EN: trivial operations jump straight from IDLE to DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      OpSel,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic            Stall,
  output logic [XLEN-1:0] Result
);

  logic [1:0]        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_op;
  logic              r_neg, r_divz, r_busy, r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_sign1, w_sign2, w_neg, w_special;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_special_val, w_quot, w_rem, w_fix_result;
  logic [2*XLEN-1:0] w_step_acc, w_prod;
  logic              w_step_qbit;

  assign w_accept = (r_state == S_IDLE) && Start && !Flush;
  assign w_sign1  = op_signed1(OpSel) & Operand1[XLEN-1];
  assign w_sign2  = op_signed2(OpSel) & Operand2[XLEN-1];
  assign w_mag1   = w_sign1 ? -Operand1 : Operand1;
  assign w_mag2   = w_sign2 ? -Operand2 : Operand2;
  // Remainder follows the dividend; product and quotient follow the sign XOR.
  assign w_neg    = (OpSel[2] && OpSel[1]) ? w_sign1 : (w_sign1 ^ w_sign2);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_special     = is_special(OpSel, Operand1, Operand2);
  assign w_special_val = special_result(OpSel, Operand1, Operand2);
`else
  assign w_special     = 1'b0;
  assign w_special_val = '0;
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_is_div  (r_op[2]),
    .o_acc     (w_step_acc),
    .o_qbit    (w_step_qbit)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_divz ? RES_ALL_ONES : (r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_result = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:           w_fix_result = w_prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  w_fix_result = w_quot;
      OP_REM, OP_REMU:  w_fix_result = w_rem;
      default:          w_fix_result = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (Flush)                            w_next_state = S_IDLE;
        else if (r_cnt == CNT_W'(XLEN - 1))   w_next_state = S_FIX;
      end
      S_FIX:  w_next_state = Flush ? S_IDLE : S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_CALC) || (w_next_state == S_FIX);
      r_done  <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= OpSel;
          r_neg  <= w_neg;
          r_divz <= (Operand2 == '0);
          r_cnt  <= '0;
          r_acc  <= {{XLEN{1'b0}}, (OpSel[2] ? w_mag1 : w_mag2)};
          r_opnd <= OpSel[2] ? w_mag2 : w_mag1;
          if (w_special) r_result <= w_special_val;
        end
        S_CALC: begin
          r_acc <= {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_step_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: if (!Flush) r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;
  assign Stall  = rst_n && (w_accept || (r_state == S_CALC) || (r_state == S_FIX));

endmodule
